// File: rtl/sysmem_arbiter.sv
// Two-requester sequencer for the four byte-lane system BRAMs (CPU 32-bit port, UART loader 8-bit port).
// Every access runs IDLE -> ISSUE -> WAIT -> DONE; all outputs come straight from registers.
module sysmem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_valid,
  input  logic [ADDR_W+1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              ld_valid,
  input  logic [ADDR_W+1:0] ld_addr,
  input  logic              ld_we,
  input  logic [7:0]        ld_wdata,
  output logic              ld_ready,
  output logic [7:0]        ld_rdata,
  input  logic              ld_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_ce,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_do
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {GNT_CPU, GNT_LD} gnt_t;

  state_t state, state_d;
  gnt_t   last_grant, last_grant_d;
  gnt_t   grant, grant_d;
  gnt_t   grant_sel;
  logic   grant_valid;
  logic   is_read, is_read_d;
  logic [1:0] lane, lane_d;

  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_ce_d, mem_we_d;
  logic [31:0]       mem_di_d;
  logic              cpu_ready_d, ld_ready_d;
  logic [31:0]       cpu_rdata_d;
  logic [7:0]        ld_rdata_d;

  // The CPU port is word-aligned; its byte offset is never needed.
  logic unused_cpu_offset;
  assign unused_cpu_offset = ^cpu_addr[1:0];

  // State and output registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= GNT_LD;
      grant      <= GNT_CPU;
      is_read    <= 1'b1;
      lane       <= 2'd0;
      mem_addr   <= '0;
      mem_ce     <= '0;
      mem_we     <= '0;
      mem_di     <= '0;
      cpu_ready  <= 1'b0;
      ld_ready   <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      grant      <= grant_d;
      is_read    <= is_read_d;
      lane       <= lane_d;
      mem_addr   <= mem_addr_d;
      mem_ce     <= mem_ce_d;
      mem_we     <= mem_we_d;
      mem_di     <= mem_di_d;
      cpu_ready  <= cpu_ready_d;
      ld_ready   <= ld_ready_d;
      cpu_rdata  <= cpu_rdata_d;
      ld_rdata   <= ld_rdata_d;
    end
  end

  // Round-robin arbitration and next state.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    logic cpu_elig;
    logic ld_elig;
    cpu_elig    = cpu_valid & ~ld_lock;
    ld_elig     = ld_valid;
    grant_valid = cpu_elig | ld_elig;
    grant_sel   = GNT_LD;
    state_d     = state;
    if (cpu_elig && ld_elig)
      grant_sel = (last_grant == GNT_LD) ? GNT_CPU : GNT_LD;
    else if (cpu_elig)
      grant_sel = GNT_CPU;

    unique case (state)
      IDLE:  if (grant_valid) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  // Next values of the registered BRAM command, ready pulses and read data.
  always_comb begin
    last_grant_d = last_grant;
    grant_d      = grant;
    is_read_d    = is_read;
    lane_d       = lane;
    mem_addr_d   = mem_addr;
    mem_di_d     = mem_di;
    mem_ce_d     = 4'b0000;
    mem_we_d     = 4'b0000;
    cpu_ready_d  = 1'b0;
    ld_ready_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    ld_rdata_d   = ld_rdata;

    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          last_grant_d = grant_sel;
          grant_d      = grant_sel;
          if (grant_sel == GNT_CPU) begin
            mem_addr_d = cpu_addr[ADDR_W+1:2];
            mem_di_d   = cpu_wdata;
            is_read_d  = (cpu_wstrb == 4'b0000);
            lane_d     = 2'd0;
            mem_ce_d   = (cpu_wstrb == 4'b0000) ? 4'hF : cpu_wstrb;
            mem_we_d   = cpu_wstrb;
          end else begin
            mem_addr_d = ld_addr[ADDR_W+1:2];
            mem_di_d   = {4{ld_wdata}};
            is_read_d  = ~ld_we;
            lane_d     = ld_addr[1:0];
            mem_ce_d   = 4'b0001 << ld_addr[1:0];
            mem_we_d   = ld_we ? (4'b0001 << ld_addr[1:0]) : 4'b0000;
          end
        end
      end
      ISSUE: ;
      // BRAM output is valid for the whole WAIT cycle; capture only on reads.
      WAIT: begin
        if (grant == GNT_CPU) begin
          cpu_ready_d = 1'b1;
          if (is_read) cpu_rdata_d = mem_do;
        end else begin
          ld_ready_d = 1'b1;
          if (is_read) ld_rdata_d = mem_do[{lane, 3'b000} +: 8];
        end
      end
      DONE: ;
    endcase
  end

endmodule

// File: tb/tb_sysmem_arbiter.sv
// Bench for sysmem_arbiter: byte-lane BRAM model, transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sysmem_arbiter;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cpu_valid = 1'b0;
  logic [ADDR_W+1:0] cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [3:0]        cpu_wstrb = '0;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;
  logic              ld_valid = 1'b0;
  logic [ADDR_W+1:0] ld_addr = '0;
  logic              ld_we = 1'b0;
  logic [7:0]        ld_wdata = '0;
  logic              ld_ready;
  logic [7:0]        ld_rdata;
  logic              ld_lock = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_ce;
  logic [3:0]        mem_we;
  logic [31:0]       mem_di;
  logic [31:0]       mem_do;

  sysmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_we(ld_we), .ld_wdata(ld_wdata),
    .ld_ready(ld_ready), .ld_rdata(ld_rdata), .ld_lock(ld_lock),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we), .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  // Four 1024x8 read-first BRAMs, output updated on enabled edges only.
  logic [7:0] bram [4][1 << ADDR_W];
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (mem_ce[n]) begin
        if (mem_we[n]) bram[n][mem_addr] <= mem_di[8*n +: 8];
        mem_do[8*n +: 8] <= bram[n][mem_addr];
      end
    end
  end

  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef enum int {M_CPU = 0, M_LD = 1} req_t;
  logic [31:0]       ref_mem [1 << ADDR_W];
  int                age;          // cycles since grant edge, -1 when no access in flight
  req_t              m_grant, m_last;
  logic              m_read;
  logic [1:0]        m_lane;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_di, m_rword, e_cpu_rdata;
  logic [3:0]        m_ce, m_we;
  logic [7:0]        e_ld_rdata;

  task automatic model_reset();
    age = -1; m_last = M_LD; m_grant = M_CPU; m_read = 1'b1; m_lane = 2'd0;
    m_addr = '0; m_di = '0; m_ce = '0; m_we = '0; m_rword = '0;
    e_cpu_rdata = '0; e_ld_rdata = '0;
  endtask

  task automatic model_arbitrate();
    bit c_el, l_el;
    c_el = cpu_valid && !ld_lock;
    l_el = ld_valid;
    if (c_el || l_el) begin
      if (c_el && l_el) m_grant = (m_last == M_CPU) ? M_LD : M_CPU;
      else              m_grant = c_el ? M_CPU : M_LD;
      m_last = m_grant;
      age = 0;
      if (m_grant == M_CPU) begin
        m_addr = cpu_addr[ADDR_W+1:2];
        m_di   = cpu_wdata;
        m_read = (cpu_wstrb == 4'd0);
        m_lane = 2'd0;
        m_ce   = m_read ? 4'hF : cpu_wstrb;
        m_we   = cpu_wstrb;
        for (int b = 0; b < 4; b++)
          if (cpu_wstrb[b]) ref_mem[m_addr][8*b +: 8] = cpu_wdata[8*b +: 8];
      end else begin
        m_addr = ld_addr[ADDR_W+1:2];
        m_lane = ld_addr[1:0];
        m_di   = {4{ld_wdata}};
        m_read = !ld_we;
        m_ce   = 4'b0001 << m_lane;
        m_we   = ld_we ? m_ce : 4'b0000;
        if (ld_we) ref_mem[m_addr][8*m_lane +: 8] = ld_wdata;
      end
      m_rword = ref_mem[m_addr];
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = '0;
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else begin
        if (age == 3) age = -1;
        else if (age >= 0) begin
          age++;
          if (age == 2 && m_read) begin
            if (m_grant == M_CPU) e_cpu_rdata = m_rword;
            else                  e_ld_rdata  = m_rword[8*m_lane +: 8];
          end
        end
        if (age == -1) model_arbitrate();
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("cpu_ready", cpu_ready, (age == 2 && m_grant == M_CPU));
      check("ld_ready",  ld_ready,  (age == 2 && m_grant == M_LD));
      check("mem_ce",    mem_ce,    (age == 0) ? m_ce : 4'b0);
      check("mem_we",    mem_we,    (age == 0) ? m_we : 4'b0);
      check("mem_addr",  mem_addr,  m_addr);
      check("mem_di",    mem_di,    m_di);
      check("cpu_rdata", cpu_rdata, e_cpu_rdata);
      check("ld_rdata",  ld_rdata,  e_ld_rdata);
    end
  end

  // ---------------- drivers ----------------
  task automatic cpu_access(input logic [ADDR_W+1:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat, output logic [3:0] ce_s,
                            output logic [3:0] we_s, output logic [ADDR_W-1:0] addr_s);
    bit got;
    got = 1'b0;
    @(negedge clk);
    cpu_addr = addr; cpu_wstrb = strb; cpu_wdata = wdata; cpu_valid = 1'b1;
    lat = 0; ce_s = '0; we_s = '0; addr_s = '0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin ce_s = mem_ce; we_s = mem_we; addr_s = mem_addr; end
      got = cpu_ready;
    end
    check("cpu_handshake", got, 1);
    rdata = cpu_rdata;
    cpu_valid = 1'b0; cpu_wstrb = '0;
    @(negedge clk);
    check("cpu_pulse_width", cpu_ready, 0);
  endtask

  task automatic ld_access(input logic [ADDR_W+1:0] addr, input logic we, input logic [7:0] wdata,
                           output logic [7:0] rdata, output logic [3:0] ce_s, output logic [3:0] we_s);
    bit got;
    int lat;
    got = 1'b0; lat = 0;
    @(negedge clk);
    ld_addr = addr; ld_we = we; ld_wdata = wdata; ld_valid = 1'b1;
    ce_s = '0; we_s = '0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin ce_s = mem_ce; we_s = mem_we; end
      got = ld_ready;
    end
    check("ld_handshake", got, 1);
    check("ld_latency", lat, 3);
    rdata = ld_rdata;
    ld_valid = 1'b0; ld_we = 1'b0;
    @(negedge clk);
    check("ld_pulse_width", ld_ready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0]       rd;
    logic [7:0]        lrd;
    int                lat;
    logic [3:0]        ce_s, we_s;
    logic [ADDR_W-1:0] a_s;
    int                order [4];
    int                seen;
    int                cyc;
    bit                got;

    repeat (2) @(negedge clk);
    check("reset_cpu_ready", cpu_ready, 0);
    check("reset_mem_ce", mem_ce, 0);
    check("reset_mem_addr", mem_addr, 0);
    #2 resetn = 1'b1;

    // Full-word write then readback.
    cpu_access(12'h010, 4'hF, 32'hDEADBEEF, rd, lat, ce_s, we_s, a_s);
    check("t1_wr_addr", a_s, 4);
    check("t1_wr_we", we_s, 4'hF);
    check("t1_wr_ce", ce_s, 4'hF);
    cpu_access(12'h010, 4'h0, 32'h0, rd, lat, ce_s, we_s, a_s);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_latency", lat, 3);
    check("t1_rd_ce", ce_s, 4'hF);
    check("t1_rd_we", we_s, 4'h0);

    // Partial-strobe write over a preloaded word.
    cpu_access(12'h020, 4'hF, 32'h11223344, rd, lat, ce_s, we_s, a_s);
    cpu_access(12'h020, 4'b0010, 32'h0000AB00, rd, lat, ce_s, we_s, a_s);
    check("t2_ce", ce_s, 4'b0010);
    check("t2_we", we_s, 4'b0010);
    check("t2_addr", a_s, 8);
    cpu_access(12'h020, 4'h0, 32'h0, rd, lat, ce_s, we_s, a_s);
    check("t2_readback", rd, 32'h1122AB44);

    // Loader byte write to lane 3, seen by both ports.
    ld_access(12'h013, 1'b1, 8'h5A, lrd, ce_s, we_s);
    check("t3_ld_ce", ce_s, 4'b1000);
    check("t3_ld_we", we_s, 4'b1000);
    cpu_access(12'h010, 4'h0, 32'h0, rd, lat, ce_s, we_s, a_s);
    check("t3_cpu_top_byte", rd[31:24], 8'h5A);
    check("t3_cpu_word", rd, 32'h5AADBEEF);
    ld_access(12'h013, 1'b0, 8'h00, lrd, ce_s, we_s);
    check("t3_ld_rdata", lrd, 8'h5A);
    ld_access(12'h011, 1'b0, 8'h00, lrd, ce_s, we_s);
    check("t3_ld_lane1", lrd, 8'hBE);

    // Both requesters held continuously from reset: strict alternation, CPU first.
    do_reset();
    @(negedge clk);
    cpu_addr = 12'h010; cpu_wstrb = 4'h0; cpu_valid = 1'b1;
    ld_addr = 12'h013; ld_we = 1'b0; ld_valid = 1'b1;
    seen = 0; cyc = 0;
    while (seen < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) begin order[seen] = int'(M_CPU); seen++; end
      else if (ld_ready) begin order[seen] = int'(M_LD); seen++; end
    end
    cpu_valid = 1'b0; ld_valid = 1'b0;
    check("rr_count", seen, 4);
    check("rr_grant0", order[0], 0);
    check("rr_grant1", order[1], 1);
    check("rr_grant2", order[2], 0);
    check("rr_grant3", order[3], 1);
    check("rr_cycles", cyc, 15);
    repeat (2) @(negedge clk);

    // Lock window: CPU starved while locked, served right after release.
    @(negedge clk);
    cpu_addr = 12'h020; cpu_wstrb = 4'h0; cpu_valid = 1'b1; ld_lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("lock_cpu_ready", cpu_ready, 0);
      check("lock_mem_ce", mem_ce, 0);
    end
    ld_lock = 1'b0;
    @(negedge clk);
    check("unlock_grant_ce", mem_ce, 4'hF);
    lat = 1; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = cpu_ready;
    end
    check("unlock_latency", lat, 3);
    check("unlock_rdata", cpu_rdata, 32'h1122AB44);
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT of a CPU read aborts it without a ready pulse.
    @(negedge clk);
    cpu_addr = 12'h010; cpu_wstrb = 4'h0; cpu_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_mem_ce", mem_ce, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_di", mem_di, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ld_rdata", ld_rdata, 0);
    cpu_valid = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_ready", cpu_ready, 0);
    end
    cpu_access(12'h010, 4'h0, 32'h0, rd, lat, ce_s, we_s, a_s);
    check("rst_reissue_data", rd, 32'h5AADBEEF);
    check("rst_reissue_latency", lat, 3);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/sysmem_arbiter.md
Name: sysmem_arbiter

Overview:
- Sequences and shares the four 8-bit byte-lane single-port system BRAMs (1024x8 each, unregistered output, 1-cycle read) between two requesters.
- Requester 1 is the PicoRV32 native memory port (32-bit, byte strobes).
- Requester 2 is the UART program loader/debug port (8-bit, byte-addressed).
- Sits between the CPU/loader and the BRAM instances in the SoC top; owns all BRAM addr/ce/we/di pins.

Parameters:
- ADDR_W, 10, word-address width of each byte-lane BRAM (depth = 2^ADDR_W words).

Ports:
- clk, input, 1, system clock; all BRAM clka pins share it.
- resetn, input, 1, asynchronous active-low reset.
- cpu_valid, input, 1, CPU request valid (PicoRV32 mem_valid gated by the top-level decoder).
- cpu_addr, input, ADDR_W+2, CPU byte address; bits [1:0] ignored.
- cpu_wdata, input, 32, CPU write data; lane n = bits [8n+7:8n].
- cpu_wstrb, input, 4, byte strobes; 0 = read.
- cpu_ready, output, 1, one-cycle completion pulse.
- cpu_rdata, output, 32, read data; valid while cpu_ready is high.
- ld_valid, input, 1, loader request valid.
- ld_addr, input, ADDR_W+2, loader byte address.
- ld_we, input, 1, loader write (1) or read (0).
- ld_wdata, input, 8, loader write byte.
- ld_ready, output, 1, one-cycle completion pulse.
- ld_rdata, output, 8, loader read byte; valid while ld_ready is high.
- ld_lock, input, 1, while high the CPU is never granted (program-load window).
- mem_addr, output, ADDR_W, word address shared by all lanes.
- mem_ce, output, 4, per-lane BRAM clock enable.
- mem_we, output, 4, per-lane BRAM write enable.
- mem_di, output, 32, per-lane write data.
- mem_do, input, 32, per-lane BRAM read data (doa), unregistered.

Behaviour:
- Reset (async, resetn=0): state IDLE.
  - mem_addr=0, mem_ce=0, mem_we=0, mem_di=0.
  - cpu_ready=0, ld_ready=0, cpu_rdata=0, ld_rdata=0.
  - last_grant=LD, so the CPU wins the first tie.
- Reset mid-transaction aborts the access. A write whose command was already presented may or may not have landed; requesters must reissue.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE arbitration at a clock edge:
  - CPU eligible = cpu_valid & ~ld_lock.
  - LD eligible = ld_valid.
  - Only one eligible requester: grant it.
  - Both eligible: grant the one not equal to last_grant (round-robin).
  - On grant: load the command registers, update last_grant, go to ISSUE.
  - No eligible requester: stay in IDLE; mem_ce=0, mem_we=0.
- Command encoding for a CPU grant:
  - mem_addr = cpu_addr[ADDR_W+1:2]; mem_di = cpu_wdata.
  - Read: mem_ce=4'hF, mem_we=0.
  - Write: mem_ce=cpu_wstrb, mem_we=cpu_wstrb.
- Command encoding for an LD grant:
  - lane = ld_addr[1:0]; mem_addr = ld_addr[ADDR_W+1:2].
  - mem_ce and mem_we use one-hot bit `lane`; mem_we is set only if ld_we.
  - ld_wdata is replicated into all four lanes of mem_di.
- Address bits above ADDR_W+1 do not exist at the port. The top-level decoder guarantees range.
- ISSUE: the command is stable on the BRAM pins; the BRAM samples it at the end of this cycle. Next state is WAIT. At that edge mem_ce and mem_we clear to 0; mem_addr and mem_di hold.
- WAIT: mem_do is valid.
  - Read: at the edge, capture mem_do into cpu_rdata (CPU) or mem_do lane `lane` into ld_rdata (LD).
  - Write: the rdata registers hold their previous value.
  - Set the granted requester's ready to 1; go to DONE.
- DONE: ready is high for exactly this cycle. At the edge, ready clears and the state returns to IDLE.
- A requester still asserting valid in the first IDLE cycle after DONE is arbitrated as a new request. PicoRV32 drops mem_valid at the edge where it samples ready, so no double-issue occurs.
- Latency: valid sampled at edge E0 → ready high during the cycle after E2 (3 cycles).
- Maximum throughput is one access per 4 cycles.
- A requester that drops valid before ready is still completed. The ready pulse is harmless.
- ld_lock rising while a CPU access is in flight does not abort it. The lock takes effect at the next arbitration.
- Write data is ignored on reads; strobes are ignored when cpu_wstrb=0.

Test Plan:
- Reset, then CPU write addr 0x010 wstrb=4'hF data 0xDEADBEEF, then read 0x010 → ISSUE cycle shows mem_addr=4, mem_we=4'hF; read returns cpu_rdata=0xDEADBEEF with ready 3 cycles after valid; one-cycle pulse.
- CPU write 0x020 wstrb=4'b0010 data 0x0000AB00 over a word preloaded 0x11223344 → mem_ce=mem_we=4'b0010; readback 0x1122AB44.
- Loader write ld_addr=0x013 data 0x5A, then CPU read 0x010 → mem_ce/mem_we=4'b1000 on the write; CPU reads 0x5Axxxxxx in the top byte; loader read of 0x013 returns ld_rdata=0x5A.
- cpu_valid and ld_valid both held high continuously for 4 transactions from reset → grants alternate CPU, LD, CPU, LD; no requester is granted twice in a row.
- ld_lock=1 with cpu_valid=1 held and loader idle for 20 cycles → cpu_ready stays 0 and mem_ce stays 0; lock released → CPU granted within 1 cycle, completes 3 cycles later.
- resetn pulsed low during WAIT of a CPU read → all outputs 0 immediately; FSM in IDLE; no ready pulse; the reissued read completes normally.
